sc_stream_counter: RTL and testbench
====================================

Name: sc_stream_counter

Overview:
- Stochastic-to-binary converter that sits directly downstream of the lfsr-based bitstream source.
- Counts the ones in a single-bit stochastic stream over a programmable window of valid bits.
- Presents the count, with the window length, on a valid/ready output for downstream binary logic or for checking the stream.
- Software or a controller starts each window; results are held until they are accepted.

Parameters:
CNT_W, 8, width of window length, accumulator and result; max window = 2^CNT_W - 1 bits

Ports:
clk      input   1      system clock, all state on rising edge
rst      input   1      asynchronous reset, active-low (rst=0 resets)
bit_in   input   1      stochastic stream bit (e.g. lfsr q)
bit_vld  input   1      bit_in qualifier; only bits with bit_vld=1 are counted
start    input   1      request to begin a window; sampled in IDLE and in HOLD on accept
win_len  input   CNT_W  window length in valid bits, latched on accepted start
busy     output  1      1 while in ACCUM
out_cnt  output  CNT_W  number of ones in the completed window
out_len  output  CNT_W  latched window length for that result
out_vld  output  1      result valid
out_rdy  input   1      downstream accepts result when out_vld and out_rdy are both 1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, out_vld=0, out_cnt=0, out_len=0.
  - Internal accumulator and remaining counter cleared.
  - A reset mid-window discards the partial count; no result is emitted.
- States:
  - IDLE to ACCUM: start=1 and win_len!=0.
    - len_q = win_len, acc = 0, rem = win_len.
    - busy=1 from the next cycle.
  - IDLE: start=1 with win_len=0 is ignored; stay in IDLE.
  - ACCUM, each cycle with bit_vld=1:
    - acc += bit_in, rem -= 1.
    - bit_vld=0 leaves acc and rem unchanged; gaps are unlimited.
  - ACCUM to HOLD: on the edge sampling a valid bit with rem==1.
    - out_cnt = acc + bit_in, out_len = len_q, out_vld=1, busy=0.
    - Latency: out_vld rises on the same edge that samples the last valid bit.
  - ACCUM: start is ignored; win_len changes are ignored (len_q is latched).
  - HOLD:
    - out_vld=1; out_cnt and out_len are stable until accepted.
    - bit_vld and bit_in are ignored; bits are not buffered.
  - HOLD, on out_vld&out_rdy:
    - If start=1 and win_len!=0, go to ACCUM with the new window (back-to-back, no idle cycle).
    - Otherwise go to IDLE with out_vld=0.
    - out_cnt and out_len keep their last values after acceptance.
  - HOLD: start without out_rdy is ignored.
- Arithmetic:
  - acc and rem are CNT_W wide, unsigned.
  - acc <= len_q <= 2^CNT_W-1, so acc never overflows; no saturation logic is required.
- Stream bits are counted only while busy=1.

Test Plan:
- Reset pulse, then start with win_len=15 and the lfsr (seed 4'b0001, load pulse) driving bit_in with bit_vld=1 continuously for 15 cycles -> out_cnt=8, out_len=15, out_vld rises on the edge sampling the 15th bit.
- win_len=255, bit_in=1 constant, bit_vld toggling 1/0 every cycle -> result after 510 cycles: out_cnt=255, no wrap. Repeat with bit_in=0 -> out_cnt=0.
- win_len=4, bits 1,0,1,1 with bit_vld low for 3 cycles between each bit -> out_cnt=3; busy stays 1 through the gaps.
- Backpressure: result ready with out_rdy=0 for 10 cycles while bit_vld=1, bit_in=1 -> out_vld, out_cnt and out_len constant. Then out_rdy=1 with start=1, win_len=2, bits 1,1 -> next result out_cnt=2 with no IDLE cycle in between.
- Reset mid-window: start win_len=10, pull rst low after 5 ones -> out_vld=0 and busy=0 immediately. A fresh win_len=3 window of 0,0,1 -> out_cnt=1, with no stale count.
- start with win_len=0 in IDLE -> remains IDLE, busy=0, out_vld=0. start pulses during ACCUM are ignored and the window length is unchanged.

Source files
------------

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones in a programmable window of valid
// stream bits and holds the count on a valid/ready result port until accepted.
module sc_stream_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] out_cnt,
  output logic [CNT_W-1:0] out_len,
  output logic             out_vld,
  input  logic             out_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] rem_r, rem_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [CNT_W-1:0] out_cnt_r, out_cnt_s;
  logic [CNT_W-1:0] out_len_r, out_len_s;
  logic             out_vld_r, out_vld_s;
  logic             busy_r, busy_s;
  logic [CNT_W-1:0] bit_ext_s;
  logic             start_ok_s;

  assign bit_ext_s  = {{(CNT_W-1){1'b0}}, bit_in};
  assign start_ok_s = start && (win_len != ZERO);

  // Next-state and datapath: latch window on start, count valid bits, hold result
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    rem_s     = rem_r;
    len_s     = len_r;
    out_cnt_s = out_cnt_r;
    out_len_s = out_len_r;
    out_vld_s = out_vld_r;
    busy_s    = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_s = ST_ACCUM;
          len_s   = win_len;
          acc_s   = ZERO;
          rem_s   = win_len;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bit_vld) begin
          if (rem_r == ONE) begin
            // Final bit goes straight into the result so out_vld rises on this edge
            state_s   = ST_HOLD;
            out_cnt_s = acc_r + bit_ext_s;
            out_len_s = len_r;
            out_vld_s = 1'b1;
            busy_s    = 1'b0;
            acc_s     = ZERO;
            rem_s     = ZERO;
          end else begin
            acc_s = acc_r + bit_ext_s;
            rem_s = rem_r - ONE;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_rdy) begin
          out_vld_s = 1'b0;
          if (start_ok_s) begin
            state_s = ST_ACCUM;
            len_s   = win_len;
            acc_s   = ZERO;
            rem_s   = win_len;
            busy_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        acc_s     = ZERO;
        rem_s     = ZERO;
        out_vld_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      acc_r     <= ZERO;
      rem_r     <= ZERO;
      len_r     <= ZERO;
      out_cnt_r <= ZERO;
      out_len_r <= ZERO;
      out_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      rem_r     <= rem_s;
      len_r     <= len_s;
      out_cnt_r <= out_cnt_s;
      out_len_r <= out_len_s;
      out_vld_r <= out_vld_s;
      busy_r    <= busy_s;
    end
  end

  assign busy    = busy_r;
  assign out_cnt = out_cnt_r;
  assign out_len = out_len_r;
  assign out_vld = out_vld_r;

endmodule

// File: tb/tb_sc_stream_counter.sv
// Bench for sc_stream_counter: directed scenarios plus random traffic, checked
// every cycle against a window/queue model of the counter's behaviour.
module tb_sc_stream_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_vld = 1'b0;
  logic       start = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic       busy;
  logic [7:0] out_cnt;
  logic [7:0] out_len;
  logic       out_vld;
  logic       out_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model: a window is open or a result is held; bits of the open window are queued
  logic m_busy = 1'b0;
  logic m_vld = 1'b0;
  int   m_len = 0;
  int   m_cnt = 0;
  int   m_olen = 0;
  bit   win_q[$];
  logic [3:0] lq;

  sc_stream_counter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .start(start),
    .win_len(win_len), .busy(busy), .out_cnt(out_cnt), .out_len(out_len),
    .out_vld(out_vld), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ones_in_window();
    int n = 0;
    foreach (win_q[i]) n += int'(win_q[i]);
    return n;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".vld"}, 32'(out_vld), 32'(m_vld));
    chk({tag, ".cnt"}, 32'(out_cnt), 32'(m_cnt));
    chk({tag, ".len"}, 32'(out_len), 32'(m_olen));
  endtask

  // One clock: apply inputs, advance the model, then compare just after the edge
  task automatic cyc(input logic s, input logic [7:0] wl, input logic b,
                     input logic v, input logic r, input string tag);
    start = s; win_len = wl; bit_in = b; bit_vld = v; out_rdy = r;
    if (m_busy) begin
      if (v) begin
        win_q.push_back(b);
        if (win_q.size() == m_len) begin
          m_cnt = ones_in_window();
          m_olen = m_len;
          m_vld = 1'b1;
          m_busy = 1'b0;
        end
      end
    end else if (m_vld) begin
      if (r) begin
        m_vld = 1'b0;
        if (s && wl != 8'd0) begin
          m_busy = 1'b1; m_len = int'(wl); win_q.delete();
        end
      end
    end else if (s && wl != 8'd0) begin
      m_busy = 1'b1; m_len = int'(wl); win_q.delete();
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    start = 1'b0; bit_vld = 1'b0; out_rdy = 1'b0;
    #1;
    m_busy = 1'b0; m_vld = 1'b0; m_cnt = 0; m_olen = 0; win_q.delete();
    compare_all(tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare_all({tag, ".post"});
  endtask

  initial begin
    do_reset("reset");

    // Window of 15 fed by a maximal 4-bit lfsr seeded with 4'b0001
    lq = 4'b0001;
    cyc(1'b1, 8'd15, 1'b0, 1'b0, 1'b0, "lfsr.start");
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'd15, lq[0], 1'b1, 1'b0, "lfsr.bit");
      lq = {lq[2:0], lq[3] ^ lq[2]};
      if (i < 14) chk("lfsr.vld_early", 32'(out_vld), 32'd0);
    end
    chk("lfsr.cnt8", 32'(out_cnt), 32'd8);
    chk("lfsr.len15", 32'(out_len), 32'd15);
    chk("lfsr.vld", 32'(out_vld), 32'd1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "lfsr.accept");

    // Maximum window with bit_vld toggling: all ones then all zeros
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, "max.start");
      for (int i = 0; i < 510; i++)
        cyc(1'b0, 8'd0, (pass == 0), (i % 2 == 0), 1'b0, "max.bit");
      chk("max.cnt", 32'(out_cnt), (pass == 0) ? 32'd255 : 32'd0);
      chk("max.len", 32'(out_len), 32'd255);
      cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "max.accept");
    end

    // Window of 4 with three-cycle gaps between valid bits
    cyc(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, "gap.start");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'd0, (i != 1), 1'b1, 1'b0, "gap.bit");
      if (i < 3)
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, "gap.idle");
          chk("gap.busy", 32'(busy), 32'd1);
        end
    end
    chk("gap.cnt3", 32'(out_cnt), 32'd3);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "gap.accept");

    // Backpressure on a held result, then back-to-back window of 2
    cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "bp.start");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 8'd0, 1'($urandom), 1'b1, 1'b0, "bp.bit");
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom), 8'd7, 1'b1, 1'b1, 1'b0, "bp.hold");
    chk("bp.len5", 32'(out_len), 32'd5);
    cyc(1'b1, 8'd2, 1'b1, 1'b1, 1'b1, "bp.accept");
    chk("bp.b2b_busy", 32'(busy), 32'd1);
    cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "bp.b1");
    cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "bp.b2");
    chk("bp.cnt2", 32'(out_cnt), 32'd2);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "bp.accept2");

    // Reset in the middle of a window, then a fresh short window
    cyc(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, "rmid.start");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "rmid.bit");
    do_reset("rmid.reset");
    cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, "rmid.start2");
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "rmid.b0");
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "rmid.b1");
    cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, "rmid.b2");
    chk("rmid.cnt1", 32'(out_cnt), 32'd1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "rmid.accept");

    // Zero-length start ignored; starts during a window do not alter it
    cyc(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "zero.start");
    chk("zero.busy", 32'(busy), 32'd0);
    cyc(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, "ign.start");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 8'(i + 1), 1'b1, 1'b1, 1'b0, "ign.bit");
    chk("ign.len6", 32'(out_len), 32'd6);
    chk("ign.cnt6", 32'(out_cnt), 32'd6);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "ign.accept");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) == 0, 8'($urandom % 21), 1'($urandom),
          1'($urandom), ($urandom % 3) == 0, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
